multi_channel_clock_gate: RTL and testbench

MULTI_CHANNEL_CLOCK_GATE -- requirements
Module: multi_channel_clock_gate

---
 rtl/clock_gating_pkg.sv | 17 +
 rtl/cg_latch_cell.sv | 20 ++
 rtl/multi_channel_clock_gate.sv | 126 ++++++++++++
 tb/tb_multi_channel_clock_gate.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_gating_pkg.sv
// Shared types and default constants for the multi-channel clock gate.
// The state enum is 2 bits wide so each channel FSM costs two flops.
package clock_gating_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_RUN  = 2'b10,
    ST_HOLD = 2'b11
  } cg_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_IDLE_CNT_W  = 4;
  localparam int DEF_WAKE_CYCLES = 2;
  localparam int WAKE_CNT_W      = 4;

endpackage

// File: rtl/cg_latch_cell.sv
// One gated-clock cell: negative-level latch on the enable followed by an AND.
// The enable only changes while the clock is low, so a high phase is never cut short.
module cg_latch_cell (
  input  logic i_clk,
  input  logic i_en,
  output logic o_gclk
);

  logic r_en_lat;

  // Enable latch, transparent during the low phase of the source clock
  always_latch begin
    if (!i_clk) begin
      r_en_lat <= i_en;
    end
  end

  assign o_gclk = i_clk & r_en_lat;

endmodule

// File: rtl/multi_channel_clock_gate.sv
// Per-channel idle-based clock gating: each channel runs its own RUN/HOLD/OFF/WAKE FSM,
// and a latch+AND cell per channel produces the gated clock from the registered enable.
module multi_channel_clock_gate
  import clock_gating_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int IDLE_CNT_W  = DEF_IDLE_CNT_W,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     clk_enable,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  input  logic                  test_en,
  output logic [NUM_CH-1:0]     gated_clock,
  output logic [NUM_CH-1:0]     ch_ready
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_ZERO = IDLE_CNT_W'(1'b0);
  localparam logic [IDLE_CNT_W-1:0] IDLE_ONE  = IDLE_CNT_W'(1'b1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_ONE  = WAKE_CNT_W'(1'b1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYCLES);

  cg_state_e               r_state    [NUM_CH];
  logic [IDLE_CNT_W-1:0]   r_idle_cnt [NUM_CH];
  logic [WAKE_CNT_W-1:0]   r_wake_cnt [NUM_CH];
  logic [NUM_CH-1:0]       r_gate_en;
  logic [NUM_CH-1:0]       r_ch_ready;
  logic [NUM_CH-1:0]       w_gate_d;

  // Channel FSMs with registered gate enable and ready flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]    <= ST_OFF;
        r_idle_cnt[i] <= IDLE_ZERO;
        r_wake_cnt[i] <= WAKE_CNT_W'(1'b0);
      end
      r_gate_en  <= '0;
      r_ch_ready <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (r_state[i])
          ST_RUN: begin
            if (!clk_enable[i]) begin
              if (idle_thresh == IDLE_ZERO) begin
                r_state[i]    <= ST_OFF;
                r_gate_en[i]  <= 1'b0;
                r_ch_ready[i] <= 1'b0;
              end else begin
                r_state[i]    <= ST_HOLD;
                r_idle_cnt[i] <= idle_thresh;
                r_gate_en[i]  <= 1'b1;
                r_ch_ready[i] <= 1'b1;
              end
            end else begin
              r_state[i]    <= ST_RUN;
              r_gate_en[i]  <= 1'b1;
              r_ch_ready[i] <= 1'b1;
            end
          end
          ST_HOLD: begin
            // A returning request cancels the countdown without ever gating
            if (clk_enable[i]) begin
              r_state[i]    <= ST_RUN;
              r_gate_en[i]  <= 1'b1;
              r_ch_ready[i] <= 1'b1;
            end else if (r_idle_cnt[i] == IDLE_ONE) begin
              r_state[i]    <= ST_OFF;
              r_idle_cnt[i] <= IDLE_ZERO;
              r_gate_en[i]  <= 1'b0;
              r_ch_ready[i] <= 1'b0;
            end else begin
              r_state[i]    <= ST_HOLD;
              r_idle_cnt[i] <= r_idle_cnt[i] - IDLE_ONE;
              r_gate_en[i]  <= 1'b1;
              r_ch_ready[i] <= 1'b1;
            end
          end
          ST_OFF: begin
            if (clk_enable[i]) begin
              r_state[i]    <= ST_WAKE;
              r_wake_cnt[i] <= WAKE_LOAD;
              r_gate_en[i]  <= 1'b1;
              r_ch_ready[i] <= 1'b0;
            end else begin
              r_state[i]    <= ST_OFF;
              r_gate_en[i]  <= 1'b0;
              r_ch_ready[i] <= 1'b0;
            end
          end
          ST_WAKE: begin
            r_wake_cnt[i] <= r_wake_cnt[i] - WAKE_ONE;
            r_gate_en[i]  <= 1'b1;
            if (r_wake_cnt[i] == WAKE_ONE) begin
              r_state[i]    <= ST_RUN;
              r_ch_ready[i] <= 1'b1;
            end else begin
              r_state[i]    <= ST_WAKE;
              r_ch_ready[i] <= 1'b0;
            end
          end
          default: begin
            r_state[i]    <= ST_OFF;
            r_idle_cnt[i] <= IDLE_ZERO;
            r_wake_cnt[i] <= WAKE_CNT_W'(1'b0);
            r_gate_en[i]  <= 1'b0;
            r_ch_ready[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_gate_d = r_gate_en | {NUM_CH{test_en}};
  assign ch_ready = r_ch_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cell
    cg_latch_cell u_cell (
      .i_clk  (clk),
      .i_en   (w_gate_d[g]),
      .o_gclk (gated_clock[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_clock_gate.sv
// Bench for multi_channel_clock_gate: directed vector table, a test-override sequence,
// and randomized traffic against a cycle-timestamp reference model.
module tb_multi_channel_clock_gate;

  localparam int NCH = 4;
  localparam int ITW = 4;
  localparam int WC  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           test_en = 1'b0;
  logic [NCH-1:0] clk_enable = '0;
  logic [ITW-1:0] idle_thresh = 4'd3;
  logic [NCH-1:0] gated_clock;
  logic [NCH-1:0] ch_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_channel_clock_gate #(
    .NUM_CH      (NCH),
    .IDLE_CNT_W  (ITW),
    .WAKE_CYCLES (WC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_enable  (clk_enable),
    .idle_thresh (idle_thresh),
    .test_en     (test_en),
    .gated_clock (gated_clock),
    .ch_ready    (ch_ready)
  );

  typedef struct {
    logic           rst_n;
    logic [NCH-1:0] en;
    logic [ITW-1:0] thr;
    logic [NCH-1:0] exp_g;
    logic [NCH-1:0] exp_r;
  } vec_t;

  vec_t vq[$];

  // Reference model: per channel, whether the clock is on, whether it is ready,
  // and the absolute cycle numbers at which a pending wake or shutdown completes.
  bit m_on     [NCH];
  bit m_rdy    [NCH];
  int m_off_at [NCH];
  int m_rdy_at [NCH];
  int cyc = 0;

  task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [NCH-1:0] e, input logic [ITW-1:0] t,
                     input logic [NCH-1:0] g, input logic [NCH-1:0] rd);
    vq.push_back('{r, e, t, g, rd});
  endtask

  function automatic logic [NCH-1:0] on_vec();
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_on[i];
    return v;
  endfunction

  function automatic logic [NCH-1:0] rdy_vec();
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_rdy[i];
    return v;
  endfunction

  task automatic model_edge();
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (!rst_n) begin
        m_on[i] = 1'b0; m_rdy[i] = 1'b0; m_off_at[i] = -1; m_rdy_at[i] = -1;
      end else if (!m_on[i]) begin
        if (clk_enable[i]) begin
          m_on[i] = 1'b1;
          m_rdy_at[i] = cyc + WC;
        end
      end else if (!m_rdy[i]) begin
        if (cyc == m_rdy_at[i]) begin
          m_rdy[i] = 1'b1;
          m_rdy_at[i] = -1;
        end
      end else if (m_off_at[i] < 0) begin
        if (!clk_enable[i]) begin
          if (idle_thresh == 4'd0) begin
            m_on[i] = 1'b0; m_rdy[i] = 1'b0;
          end else begin
            m_off_at[i] = cyc + int'(idle_thresh);
          end
        end
      end else if (clk_enable[i]) begin
        m_off_at[i] = -1;
      end else if (cyc == m_off_at[i]) begin
        m_on[i] = 1'b0; m_rdy[i] = 1'b0; m_off_at[i] = -1;
      end
    end
  endtask

  task automatic run_cycle(input bit chk);
    logic [NCH-1:0] exp_g;
    exp_g = on_vec() | {NCH{test_en}};
    @(posedge clk);
    #1;
    model_edge();
    if (chk) begin
      check($sformatf("rnd%0d_gclk", cyc), gated_clock, exp_g);
      check($sformatf("rnd%0d_ready", cyc), ch_ready, rdy_vec());
    end
  endtask

  initial begin
    // rst, en, thr, expected gated pulse at this edge, expected ch_ready after it
    add(1'b0, 4'b0000, 4'd3, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000, 4'd3, 4'b0000, 4'b0000);
    add(1'b1, 4'b0001, 4'd3, 4'b0000, 4'b0000);
    add(1'b1, 4'b0001, 4'd3, 4'b0001, 4'b0000);
    add(1'b1, 4'b0001, 4'd3, 4'b0001, 4'b0001);
    add(1'b1, 4'b0011, 4'd3, 4'b0001, 4'b0001);
    add(1'b1, 4'b0011, 4'd3, 4'b0011, 4'b0001);
    add(1'b1, 4'b0011, 4'd3, 4'b0011, 4'b0011);
    add(1'b1, 4'b0001, 4'd3, 4'b0011, 4'b0011);
    add(1'b1, 4'b0001, 4'd3, 4'b0011, 4'b0011);
    add(1'b1, 4'b0001, 4'd3, 4'b0011, 4'b0011);
    add(1'b1, 4'b0001, 4'd3, 4'b0011, 4'b0001);
    add(1'b1, 4'b0001, 4'd3, 4'b0001, 4'b0001);
    add(1'b1, 4'b0101, 4'd3, 4'b0001, 4'b0001);
    add(1'b1, 4'b0101, 4'd3, 4'b0101, 4'b0001);
    add(1'b1, 4'b0101, 4'd3, 4'b0101, 4'b0101);
    add(1'b1, 4'b0001, 4'd3, 4'b0101, 4'b0101);
    add(1'b1, 4'b0001, 4'd3, 4'b0101, 4'b0101);
    add(1'b1, 4'b0101, 4'd3, 4'b0101, 4'b0101);
    add(1'b1, 4'b0101, 4'd3, 4'b0101, 4'b0101);
    add(1'b1, 4'b0101, 4'd3, 4'b0101, 4'b0101);
    add(1'b1, 4'b0100, 4'd0, 4'b0101, 4'b0100);
    add(1'b1, 4'b0100, 4'd0, 4'b0100, 4'b0100);
    add(1'b1, 4'b0101, 4'd3, 4'b0100, 4'b0100);
    add(1'b1, 4'b0100, 4'd3, 4'b0101, 4'b0100);
    add(1'b1, 4'b0100, 4'd3, 4'b0101, 4'b0101);
    add(1'b1, 4'b0100, 4'd3, 4'b0101, 4'b0101);
    add(1'b1, 4'b0100, 4'd1, 4'b0101, 4'b0101);
    add(1'b1, 4'b0100, 4'd1, 4'b0101, 4'b0101);
    add(1'b1, 4'b0100, 4'd1, 4'b0101, 4'b0100);
    add(1'b1, 4'b0100, 4'd1, 4'b0100, 4'b0100);
    add(1'b1, 4'b1100, 4'd3, 4'b0100, 4'b0100);
    add(1'b0, 4'b1100, 4'd3, 4'b1100, 4'b0000);
    add(1'b0, 4'b1000, 4'd3, 4'b0000, 4'b0000);
    add(1'b1, 4'b1000, 4'd3, 4'b0000, 4'b0000);
    add(1'b1, 4'b1000, 4'd3, 4'b1000, 4'b0000);
    add(1'b1, 4'b1000, 4'd3, 4'b1000, 4'b1000);
    add(1'b1, 4'b1000, 4'd3, 4'b1000, 4'b1000);

    @(posedge clk);
    #1;
    foreach (vq[k]) begin
      rst_n       = vq[k].rst_n;
      clk_enable  = vq[k].en;
      idle_thresh = vq[k].thr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_gclk", k), gated_clock, vq[k].exp_g);
      check($sformatf("vec%0d_ready", k), ch_ready, vq[k].exp_r);
      #3;
      check($sformatf("vec%0d_gclk_high", k), gated_clock, vq[k].exp_g);
    end

    // Test override raised in the middle of a high phase with every channel off
    rst_n = 1'b0;
    clk_enable = '0;
    idle_thresh = 4'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("te_before", gated_clock, 4'b0000);
    #1;
    test_en = 1'b1;
    #2;
    check("te_no_partial", gated_clock, 4'b0000);
    @(negedge clk); #1;
    check("te_low_phase", gated_clock, 4'b0000);
    @(posedge clk); #1;
    check("te_open", gated_clock, 4'b1111);
    check("te_ready", ch_ready, 4'b0000);
    #3;
    check("te_open_high", gated_clock, 4'b1111);
    test_en = 1'b0;
    @(posedge clk); #1;
    check("te_closed", gated_clock, 4'b0000);
    check("te_closed_ready", ch_ready, 4'b0000);

    // Randomized traffic against the reference model
    rst_n = 1'b0;
    run_cycle(1'b0);
    run_cycle(1'b1);
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 3) == 0) clk_enable[i] = ~clk_enable[i];
      end
      idle_thresh = 4'($urandom_range(0, 5));
      test_en     = ($urandom_range(0, 15) == 0);
      rst_n       = ($urandom_range(0, 63) != 0);
      run_cycle(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
